fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of decode/control logic and the immediate generator.
- Holds the fetch PC and issues word requests to instruction memory over a request/grant plus in-order response interface.
- Buffers returned instructions in a small FIFO and presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also the cap on outstanding requests plus buffered entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  32  request word address, bits [1:0] always 0.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response valid, one per granted request, in order.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  redirect (taken branch/jump) this cycle.
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  instr_o/pc_o valid toward decode.
- instr_ready_i  in  1  decode accepts this cycle.
- instr_o  out  32  instruction word to decode/imm_gen.
- pc_o  out  32  PC of instr_o.
- misalign_o  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, FIFO empty.
  - Outputs: imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, misalign_o=0.
  - First request goes out in the first cycle after rst deasserts.
- Issue:
  - imem_req_o=1 when (outstanding + fifo_count) < FIFO_DEPTH and redirect_i=0 and misalign_o=0.
  - imem_addr_o=fetch_pc.
  - Once raised, req/addr stay stable until imem_gnt_i, unless a redirect occurs.
  - On req&gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
- Response (imem_rvalid_i=1): outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1, data discarded.
  - Else: push {imem_rdata_i, resp_pc}; resp_pc += 4.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
  - The credit rule guarantees a push never finds the FIFO full. rvalid with outstanding=0 is a protocol violation (assertion).
- Output:
  - instr_valid_o = (fifo_count!=0) & ~redirect_i; instr_o/pc_o = FIFO head.
  - Pop on instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle are both honoured.
  - Minimum latency: rvalid in cycle N -> instr_valid_o in cycle N+1.
  - Head holds stable while valid and not ready.
- Redirect (redirect_i=1), applied at the clock edge:
  - FIFO flushed; fetch_pc and resp_pc set to redirect_pc_i.
  - drop_cnt <= outstanding - imem_rvalid_i (covers both earlier-dropped and live in-flight requests).
  - No request issued and no pop that cycle.
  - Back-to-back redirects: the last one wins; drop_cnt stays consistent.
- Misaligned redirect (redirect_pc_i[1:0]!=0) without the feature: bits [1:0] are cleared.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 and still flushes and sets drop_cnt.
  - fetch_pc = target with bits [1:0] cleared.
  - Issue is suppressed while misalign_o=1.
  - misalign_o clears on the next aligned redirect or on reset.
- Undefined: misalign_o tied to 0; low target bits cleared silently.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after each grant, ready=1 -> addresses 0x0,0x4,0x8... in order; pc_o matches each instr_o; first instr_valid_o 2 cycles after the first grant.
- ready=0 for 10 cycles -> at most FIFO_DEPTH=2 entries plus 0 outstanding; imem_req_o=0; head held at pc 0x0; on ready=1 the stream resumes with no loss or duplication.
- Two requests in flight, redirect to 0x100 -> both late responses dropped; next instr_valid_o shows pc_o=0x100 with that response's data.
- Redirect coincident with rvalid and with pending gnt -> that rvalid discarded; drop_cnt=outstanding-1; no request issued that cycle.
- fetch_pc=0xFFFF_FFFC granted -> next imem_addr_o=0x0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_o=1, imem_req_o stays 0; a redirect to 0x200 clears it and fetch resumes at 0x200. Without the macro, the same stimulus fetches from 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/grant fetch, in-order responses, small instruction FIFO toward decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises sticky misalign_o and halts issue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_count, outstanding, drop_cnt;
    logic [31:0]     fetch_pc, resp_pc;
    logic            started;
    logic            misalign_q;
    logic [CW:0]     credit_used;
    logic [31:0]     redirect_tgt;
    logic            grant, push, pop;

    // Outstanding requests plus buffered entries never exceed the FIFO depth,
    // so every accepted response is guaranteed a free slot.
    assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_o    = started & (credit_used < DEPTH_C) & ~redirect_i & ~misalign_q;
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (fifo_count != '0) & ~redirect_i;
    assign instr_o       = fifo_mem[rd_ptr].instr;
    assign pc_o          = fifo_mem[rd_ptr].pc;
    assign misalign_o    = misalign_q;
    assign redirect_tgt  = {redirect_pc_i[31:2], 2'b00};

    assign grant = imem_req_o & imem_gnt_i;
    assign pop   = instr_valid_o & instr_ready_i;
    assign push  = imem_rvalid_i & ~redirect_i & (drop_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            // NOTE: the storage is reset too, because its head drives instr_o/pc_o
            // directly and those outputs have defined reset values.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '{instr: 32'h0, pc: RESET_PC};
            end
        end else begin
            started <= 1'b1;
            if (redirect_i) begin
                fetch_pc    <= redirect_tgt;
                resp_pc     <= redirect_tgt;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                // Every request still in flight after this edge is stale.
                outstanding <= outstanding - CW'(imem_rvalid_i);
                drop_cnt    <= outstanding - CW'(imem_rvalid_i);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    fifo_mem[wr_ptr] <= '{instr: imem_rdata_i, pc: resp_pc};
                    wr_ptr           <= wr_ptr + 1'b1;
                    resp_pc          <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_count  <= fifo_count + CW'(push) - CW'(pop);
                outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
                if (imem_rvalid_i && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            misalign_q <= |redirect_pc_i[1:0];
        end
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc_i[1:0];
    assign misalign_q      = 1'b0;
`endif

    a_no_orphan_rvalid: assert property (
        @(posedge clk) disable iff (!rst) imem_rvalid_i |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model tracks requests and epochs, expected
// {instr, pc} entries are queued on accepted responses and compared at decode.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    req_t        pend_q[$];
    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          gnt_pct = 100;
    int          rv_pct = 100;
    int          ready_pct = 100;
    int          first_gnt = -1;
    int          first_valid = -1;
    logic [31:0] exp_fetch = RST_PC;
    bit          exp_mis = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        int   stale;
        bit   exp_req;
        bit   exp_valid;
        req_t p;
        @(negedge clk);
        stale = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
        check("drop_cnt", 32'(dut.drop_cnt), 32'(stale));

        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        instr_ready_i = ($urandom_range(99) < ready_pct);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = (pend_q.size() > 0) && (pend_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend_q[0].addr) : $urandom();
        #1;

        exp_req   = (pend_q.size() + sb_q.size() < DEPTH) && !redir && !exp_mis;
        exp_valid = (sb_q.size() != 0) && !redir;
        check("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, exp_fetch);
        check("valid", 32'(instr_valid_o), 32'(exp_valid));
        check("misalign", 32'(misalign_o), 32'(exp_mis));
        if (exp_valid) begin
            check("instr", instr_o, sb_q[0].instr);
            check("pc", pc_o, sb_q[0].pc);
        end
        if (instr_valid_o && first_valid < 0) first_valid = cyc;

        if (imem_rvalid_i) p = pend_q.pop_front();
        if (redir) begin
            epoch++;
            sb_q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_mis = |rpc[1:0];
`endif
        end else begin
            if (exp_valid && instr_ready_i) void'(sb_q.pop_front());
            if (imem_rvalid_i && p.epoch == epoch) sb_q.push_back('{mem_word(p.addr), p.addr});
            if (exp_req && imem_gnt_i) begin
                pend_q.push_back('{exp_fetch, epoch, cyc + lat});
                if (first_gnt < 0) first_gnt = cyc;
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, RST_PC);
        check("rst_misalign", 32'(misalign_o), 32'h0);
        rst = 1'b1;

        // Streaming with single-cycle memory latency and an always-ready decoder.
        run(20);
        check("first_lat", 32'(first_valid - first_gnt), 32'd2);

        // Decode stall: buffer fills, issue stops, head holds.
        ready_pct = 0;
        run(10);
        ready_pct = 100;
        run(10);

        // Two requests in flight when a redirect lands.
        lat = 3;
        run(8);
        step(1'b1, 32'h0000_0100);
        run(12);

        // Random handshakes with frequent, sometimes back-to-back redirects.
        lat = 2;
        gnt_pct = 70;
        rv_pct = 75;
        ready_pct = 65;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) == 0) step(1'b1, {$urandom_range(32'h3FFF), 2'b00});
            else step();
        end

        // Address wrap at the top of the space.
        lat = 1;
        gnt_pct = 100;
        rv_pct = 100;
        ready_pct = 100;
        step(1'b1, 32'hFFFF_FFF8);
        run(10);

        // Misaligned redirect, then an aligned one.
        step(1'b1, 32'h0000_0102);
        run(6);
        step(1'b1, 32'h0000_0200);
        run(8);

        // Drain: stop granting and let everything retire, within a bound.
        gnt_pct = 0;
        for (int i = 0; i < 50 && (pend_q.size() + sb_q.size()) != 0; i++) step();
        run(2);
        check("drain_outstanding", 32'(dut.outstanding), 32'h0);
        check("drain_valid", 32'(instr_valid_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
